// File: rtl/id_stage.sv
// id_stage: instruction decode stage.
// Holds the IF/ID pipeline register and the register file. Detects load-use
// and control-operand hazards. Resolves J/JAL/JR and BEQ/BNE in ID and
// returns the redirect controls and targets to fetch.
module id_stage #(
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          CLR_n,
  input  logic [31:0]   IR_in,
  input  logic [DW-1:0] PC_in,
  input  logic          ex_MemRead,
  input  logic          ex_RegWrite,
  input  logic [4:0]    ex_wreg,
  input  logic          mem_MemRead,
  input  logic [4:0]    mem_wreg,
  input  logic          wb_RegWrite,
  input  logic [4:0]    wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic [31:0]   IR_q,
  output logic [DW-1:0] PC_q,
  output logic          id_valid,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic [DW-1:0] imm_ext,
  output logic [DW-1:0] link_addr,
  output logic [DW-1:0] jaddr,
  output logic [DW-1:0] baddr,
  output logic          J,
  output logic          JAL,
  output logic          JR,
  output logic          Branch,
  output logic          stall
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  logic          vld_p1;
  logic [DW-1:0] regs [NREG];

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;

  logic is_j, is_jal, is_jr, is_beq, is_bne;
  logic uses_rt;
  logic ctl_rd_rs, ctl_rd_rt;
  logic wb_fwd;
  logic load_use, ex_ctl_haz, mem_ctl_haz;
  logic go;
  logic redirect;

  // ---- IF/ID boundary: fields of the latched instruction ----
  assign op    = IR_q[31:26];
  assign rs    = IR_q[25:21];
  assign rt    = IR_q[20:16];
  assign funct = IR_q[5:0];

  assign is_j    = (op == OP_J);
  assign is_jal  = (op == OP_JAL);
  assign is_jr   = (op == OP_RTYPE) && (funct == FN_JR);
  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = (op == OP_BNE);
  assign uses_rt = (op == OP_RTYPE) || is_beq || is_bne || (op == OP_SW);

  // Sources that control-flow resolution in ID needs right now.
  assign ctl_rd_rs = is_beq || is_bne || is_jr;
  assign ctl_rd_rt = is_beq || is_bne;

  assign wb_fwd = wb_RegWrite && (wb_rd != 5'd0);

  // Register-file reads with same-cycle write-back bypass; r0 is hardwired zero.
  always_comb begin
    rs_data = regs[rs];
    rt_data = regs[rt];
    if (wb_fwd && (wb_rd == rs)) rs_data = wb_data;
    if (wb_fwd && (wb_rd == rt)) rt_data = wb_data;
    if (rs == 5'd0) rs_data = '0;
    if (rt == 5'd0) rt_data = '0;
  end

  // Hazard detection: load-use, and branch/JR operands not yet available.
  always_comb begin
    load_use    = ex_MemRead && (ex_wreg != 5'd0) &&
                  ((ex_wreg == rs) || (uses_rt && (ex_wreg == rt)));
    ex_ctl_haz  = ex_RegWrite && (ex_wreg != 5'd0) &&
                  ((ctl_rd_rs && (ex_wreg == rs)) || (ctl_rd_rt && (ex_wreg == rt)));
    mem_ctl_haz = mem_MemRead && (mem_wreg != 5'd0) &&
                  ((ctl_rd_rs && (mem_wreg == rs)) || (ctl_rd_rt && (mem_wreg == rt)));
    stall       = vld_p1 && (load_use || ex_ctl_haz || mem_ctl_haz);
  end

  // Redirects only fire for a real, non-stalled instruction, so they can
  // never coincide with stall and are all zero while in reset.
  assign go       = vld_p1 && !stall;
  assign J        = go && is_j;
  assign JAL      = go && is_jal;
  assign JR       = go && is_jr;
  assign Branch   = go && ((is_beq && (rs_data == rt_data)) ||
                           (is_bne && (rs_data != rt_data)));
  assign redirect = J || JAL || JR || Branch;
  assign id_valid = go;

  // Target arithmetic, all modulo 2^DW.
  assign imm_ext   = {{(DW-16){IR_q[15]}}, IR_q[15:0]};
  assign link_addr = PC_q + DW'(4);
  assign baddr     = link_addr + (imm_ext << 2);
  assign jaddr     = is_jr ? rs_data : {link_addr[DW-1:DW-4], IR_q[25:0], 2'b00};

  // ---- IF/ID pipeline register: squash on redirect, hold on stall ----
  // On a squash PC_q is left as is; the bubble it accompanies is invalid.
  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      IR_q   <= '0;
      PC_q   <= '0;
      vld_p1 <= 1'b0;
    end else if (redirect) begin
      IR_q   <= '0;
      vld_p1 <= 1'b0;
    end else if (!stall) begin
      IR_q   <= IR_in;
      PC_q   <= PC_in;
      vld_p1 <= 1'b1;
    end
  end

  // Register file write port; r0 is never written.
  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_fwd) begin
      regs[wb_rd] <= wb_data;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage with hand-computed expected values.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        CLR_n;
  logic [31:0] IR_in, PC_in;
  logic        ex_MemRead, ex_RegWrite, mem_MemRead, wb_RegWrite;
  logic [4:0]  ex_wreg, mem_wreg, wb_rd;
  logic [31:0] wb_data;
  logic [31:0] IR_q, PC_q, rs_data, rt_data, imm_ext, link_addr, jaddr, baddr;
  logic        id_valid, J, JAL, JR, Branch, stall;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .CLR_n(CLR_n), .IR_in(IR_in), .PC_in(PC_in),
    .ex_MemRead(ex_MemRead), .ex_RegWrite(ex_RegWrite), .ex_wreg(ex_wreg),
    .mem_MemRead(mem_MemRead), .mem_wreg(mem_wreg),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .IR_q(IR_q), .PC_q(PC_q), .id_valid(id_valid),
    .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext),
    .link_addr(link_addr), .jaddr(jaddr), .baddr(baddr),
    .J(J), .JAL(JAL), .JR(JR), .Branch(Branch), .stall(stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    CLR_n = 1'b0; IR_in = '0; PC_in = '0;
    ex_MemRead = 0; ex_RegWrite = 0; ex_wreg = 0;
    mem_MemRead = 0; mem_wreg = 0;
    wb_RegWrite = 0; wb_rd = 0; wb_data = '0;
    tick(); tick();
    #1;
    chk("rst_IR_q", IR_q, 32'h0);
    chk("rst_PC_q", PC_q, 32'h0);
    chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_redirect", {28'b0, J, JAL, JR, Branch}, 32'h0);

    // Release reset between edges, then load addi r1,r0,5.
    CLR_n = 1'b1;
    IR_in = 32'h20010005; PC_in = 32'h0;
    tick(); #1;
    chk("addi_IR_q", IR_q, 32'h20010005);
    chk("addi_PC_q", PC_q, 32'h0);
    chk("addi_id_valid", {31'b0, id_valid}, 32'h1);
    chk("addi_stall", {31'b0, stall}, 32'h0);
    chk("addi_imm_ext", imm_ext, 32'h5);
    chk("addi_link", link_addr, 32'h4);

    // add r4,r3,r0 : bypass of r3 write in the same cycle.
    IR_in = 32'h00602020; PC_in = 32'h4;
    tick();
    wb_RegWrite = 1; wb_rd = 5'd3; wb_data = 32'h1234;
    #1;
    chk("bypass_rs", rs_data, 32'h1234);
    tick();
    wb_RegWrite = 0;
    #1;
    chk("rf_read_rs", rs_data, 32'h1234);
    // Write to r0 must neither bypass nor stick (rt field is 0).
    wb_RegWrite = 1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    #1;
    chk("r0_bypass", rt_data, 32'h0);
    tick();
    wb_RegWrite = 0;
    #1;
    chk("r0_after", rt_data, 32'h0);

    // Set r1=7, r2=7, r31=0x1C.
    wb_RegWrite = 1; wb_rd = 5'd1; wb_data = 32'd7;
    tick();
    wb_rd = 5'd2;
    tick();
    wb_rd = 5'd31; wb_data = 32'h1C;
    tick();
    wb_RegWrite = 0;

    // add r4,r2,r5 with a load to r2 in EX -> load-use stall.
    IR_in = 32'h00452020; PC_in = 32'h0C;
    tick();
    ex_MemRead = 1; ex_wreg = 5'd2;
    IR_in = 32'h0; PC_in = 32'h10;
    #1;
    chk("lu_stall", {31'b0, stall}, 32'h1);
    chk("lu_id_valid", {31'b0, id_valid}, 32'h0);
    tick(); #1;
    chk("lu_hold_IR", IR_q, 32'h00452020);
    chk("lu_hold_PC", PC_q, 32'h0C);
    ex_wreg = 5'd5;
    #1;
    chk("lu_rt_stall", {31'b0, stall}, 32'h1);
    ex_MemRead = 0;
    #1;
    chk("lu_release", {31'b0, stall}, 32'h0);
    chk("lu_release_vld", {31'b0, id_valid}, 32'h1);
    ex_wreg = 5'd0;

    // BEQ r1,r2,+3 at 0x10 -> taken to 0x20.
    IR_in = 32'h10220003; PC_in = 32'h10;
    tick(); #1;
    chk("beq_Branch", {31'b0, Branch}, 32'h1);
    chk("beq_baddr", baddr, 32'h20);
    chk("beq_J", {31'b0, J}, 32'h0);
    IR_in = 32'h20010005; PC_in = 32'h14;
    tick(); #1;
    chk("beq_squash_IR", IR_q, 32'h0);
    chk("beq_squash_vld", {31'b0, id_valid}, 32'h0);
    chk("beq_squash_br", {31'b0, Branch}, 32'h0);

    // BNE r1,r2,+3 -> not taken; then operand hazards.
    IR_in = 32'h14220003; PC_in = 32'h10;
    tick(); #1;
    chk("bne_Branch", {31'b0, Branch}, 32'h0);
    chk("bne_id_valid", {31'b0, id_valid}, 32'h1);
    ex_RegWrite = 1; ex_wreg = 5'd1;
    #1;
    chk("bne_ex_haz", {31'b0, stall}, 32'h1);
    ex_RegWrite = 0; ex_wreg = 5'd0;
    mem_MemRead = 1; mem_wreg = 5'd2;
    #1;
    chk("bne_mem_haz", {31'b0, stall}, 32'h1);
    mem_MemRead = 0; mem_wreg = 5'd0;

    // J 0x40 at PC 0x8.
    IR_in = 32'h08000010; PC_in = 32'h8;
    tick(); #1;
    chk("j_J", {31'b0, J}, 32'h1);
    chk("j_jaddr", jaddr, 32'h40);
    IR_in = 32'h03E00008; PC_in = 32'h40;
    tick(); #1;
    chk("j_squash_IR", IR_q, 32'h0);
    tick(); #1;
    chk("jr_JR", {31'b0, JR}, 32'h1);
    chk("jr_jaddr", jaddr, 32'h1C);
    IR_in = 32'h0C000010; PC_in = 32'h1C;
    tick(); tick(); #1;
    chk("jal_JAL", {31'b0, JAL}, 32'h1);
    chk("jal_link", link_addr, 32'h20);

    // Async reset in the middle of a load-use stall.
    IR_in = 32'h00452020; PC_in = 32'h30;
    tick(); tick();
    ex_MemRead = 1; ex_wreg = 5'd2;
    #1;
    chk("mid_stall", {31'b0, stall}, 32'h1);
    #1;
    CLR_n = 1'b0;
    #1;
    chk("mid_rst_IR", IR_q, 32'h0);
    chk("mid_rst_stall", {31'b0, stall}, 32'h0);
    chk("mid_rst_vld", {31'b0, id_valid}, 32'h0);
    ex_MemRead = 0; ex_wreg = 5'd0;
    #1;
    CLR_n = 1'b1;
    // BEQ r1,r2: registers must now read zero.
    IR_in = 32'h10220003; PC_in = 32'h0;
    tick(); #1;
    chk("post_rst_rs", rs_data, 32'h0);
    chk("post_rst_r31", {27'b0, IR_q[25:21]} == 32'd1 ? rs_data : 32'hFFFFFFFF, 32'h0);
    IR_in = 32'h03E00008;
    tick(); tick(); #1;
    chk("post_rst_jr", jaddr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
